// File: rtl/lookup_way_pipe_pkg.sv
// Shared LLC lookup types: tag/state/way widths, state encodings and response classes.
package lookup_way_pipe_pkg;

  localparam int unsigned LLC_WAYS    = 16;
  localparam int unsigned LLC_TAG_W   = 20;
  localparam int unsigned LLC_STATE_W = 3;
  localparam int unsigned LLC_WAY_W   = $clog2(LLC_WAYS);

  typedef logic [LLC_STATE_W-1:0] llc_state_t;
  typedef logic [LLC_WAY_W-1:0]   llc_way_t;
  typedef logic [LLC_TAG_W-1:0]   llc_tag_t;

  // Line states the lookup cares about; remaining encodings count as occupied, non-VALID, non-SD.
  localparam llc_state_t INVALID = LLC_STATE_W'(0);
  localparam llc_state_t VALID   = LLC_STATE_W'(1);
  localparam llc_state_t SD      = LLC_STATE_W'(2);

  typedef enum logic [1:0] {
    CLS_HIT         = 2'd0,
    CLS_EMPTY       = 2'd1,
    CLS_EVICT_VALID = 2'd2,
    CLS_EVICT_OTHER = 2'd3
  } llc_cls_t;

endpackage

// File: rtl/lookup_way_pipe_if.sv
// Request/response bus between the tag/state read stage, the way lookup and the LLC request FSM.
interface lookup_way_pipe_if
  import lookup_way_pipe_pkg::*;
#(
  parameter int unsigned WAYS    = LLC_WAYS,
  parameter int unsigned TAG_W   = LLC_TAG_W,
  parameter int unsigned STATE_W = LLC_STATE_W
) ();

  localparam int unsigned WAY_W = $clog2(WAYS);

  logic                    flush;
  logic                    ptr_mode;
  logic                    req_valid;
  logic                    req_ready;
  logic [TAG_W-1:0]        req_tag;
  logic [WAYS*TAG_W-1:0]   req_tags;
  logic [WAYS*STATE_W-1:0] req_states;
  logic [WAY_W-1:0]        req_evict_ptr;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [WAY_W-1:0]        rsp_way;
  logic                    rsp_evict;
  logic [1:0]              rsp_cls;
  logic                    rsp_forced;
  logic                    rsp_multi_hit;

  modport master (
    output flush, ptr_mode, req_valid, req_tag, req_tags, req_states, req_evict_ptr, rsp_ready,
    input  req_ready, rsp_valid, rsp_way, rsp_evict, rsp_cls, rsp_forced, rsp_multi_hit
  );

  modport slave (
    input  flush, ptr_mode, req_valid, req_tag, req_tags, req_states, req_evict_ptr, rsp_ready,
    output req_ready, rsp_valid, rsp_way, rsp_evict, rsp_cls, rsp_forced, rsp_multi_hit
  );

endinterface

// File: rtl/lookup_rr_prio_enc.sv
// Rotating priority encoder: first set bit of vec scanning base, base+1, ... with wrap.
module lookup_rr_prio_enc #(
  parameter  int unsigned WAYS  = 16,
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  vec,
  input  logic [WAY_W-1:0] base,
  output logic             found_c,
  output logic [WAY_W-1:0] idx_c
);

  logic [WAYS-1:0]  rot;
  logic [WAY_W-1:0] off;

  // Rotate so base lands at bit 0, pick the lowest set bit, then rotate the index back.
  always_comb begin
    rot = WAYS'({vec, vec} >> base);
    off = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (rot[i]) off = WAY_W'(i);
    end
    found_c = |rot;
    idx_c   = base + off;
  end

endmodule

// File: rtl/lookup_way_pipe.sv
// Two-stage LLC way lookup: capture tag/state snapshot, then pick hit / empty / eviction victim.
module lookup_way_pipe
  import lookup_way_pipe_pkg::*;
#(
  parameter int unsigned WAYS    = LLC_WAYS,
  parameter int unsigned TAG_W   = LLC_TAG_W,
  parameter int unsigned STATE_W = LLC_STATE_W
) (
  input logic              clk,
  input logic              rst,
  lookup_way_pipe_if.slave bus
);

  localparam int unsigned WAY_W = $clog2(WAYS);

  logic                    s1_valid_q,     s1_valid_d;
  logic [TAG_W-1:0]        s1_tag_q,       s1_tag_d;
  logic [WAYS*TAG_W-1:0]   s1_tags_q,      s1_tags_d;
  logic [WAYS*STATE_W-1:0] s1_states_q,    s1_states_d;
  logic [WAY_W-1:0]        s1_evict_ptr_q, s1_evict_ptr_d;
  logic                    rsp_valid_q,    rsp_valid_d;
  logic [WAY_W-1:0]        rsp_way_q,      rsp_way_d;
  logic                    rsp_evict_q,    rsp_evict_d;
  logic [1:0]              rsp_cls_q,      rsp_cls_d;
  logic                    rsp_forced_q,   rsp_forced_d;
  logic                    rsp_multi_q,    rsp_multi_d;
  logic [WAY_W-1:0]        rr_ptr_q,       rr_ptr_d;

  logic [WAYS-1:0]  hit_vec, empty_vec, valid_vec, not_sd_vec;
  logic             hit_found, empty_found, valid_found, not_sd_found;
  logic [WAY_W-1:0] hit_idx, empty_idx, valid_idx, not_sd_idx;
  logic [WAY_W-1:0] base_c;
  logic [WAY_W-1:0] way_nx;
  logic             evict_nx, forced_nx, multi_nx;
  logic [1:0]       cls_nx;
  logic             out_load_c, accept_c;

  // Per-way classification of the captured snapshot.
  always_comb begin
    for (int i = 0; i < int'(WAYS); i++) begin
      hit_vec[i]    = (s1_tags_q[i*TAG_W +: TAG_W] == s1_tag_q) &&
                      (s1_states_q[i*STATE_W +: STATE_W] != STATE_W'(INVALID));
      empty_vec[i]  = s1_states_q[i*STATE_W +: STATE_W] == STATE_W'(INVALID);
      valid_vec[i]  = s1_states_q[i*STATE_W +: STATE_W] == STATE_W'(VALID);
      not_sd_vec[i] = s1_states_q[i*STATE_W +: STATE_W] != STATE_W'(SD);
    end
  end

  assign base_c = bus.ptr_mode ? rr_ptr_q : s1_evict_ptr_q;

  lookup_rr_prio_enc #(.WAYS(WAYS)) u_hit_enc (
    .vec(hit_vec), .base(WAY_W'(0)), .found_c(hit_found), .idx_c(hit_idx)
  );
  lookup_rr_prio_enc #(.WAYS(WAYS)) u_empty_enc (
    .vec(empty_vec), .base(WAY_W'(0)), .found_c(empty_found), .idx_c(empty_idx)
  );
  lookup_rr_prio_enc #(.WAYS(WAYS)) u_valid_enc (
    .vec(valid_vec), .base(base_c), .found_c(valid_found), .idx_c(valid_idx)
  );
  lookup_rr_prio_enc #(.WAYS(WAYS)) u_not_sd_enc (
    .vec(not_sd_vec), .base(base_c), .found_c(not_sd_found), .idx_c(not_sd_idx)
  );

  // Way selection priority: hit, empty, VALID victim, non-SD victim, forced at base.
  always_comb begin
    way_nx    = base_c;
    evict_nx  = 1'b1;
    cls_nx    = CLS_EVICT_OTHER;
    forced_nx = 1'b0;
    multi_nx  = (hit_vec & (hit_vec - WAYS'(1))) != '0;
    if (hit_found) begin
      way_nx   = hit_idx;
      evict_nx = 1'b0;
      cls_nx   = CLS_HIT;
    end else if (empty_found) begin
      way_nx   = empty_idx;
      evict_nx = 1'b0;
      cls_nx   = CLS_EMPTY;
    end else if (valid_found) begin
      way_nx = valid_idx;
      cls_nx = CLS_EVICT_VALID;
    end else if (not_sd_found) begin
      way_nx = not_sd_idx;
    end else begin
      forced_nx = 1'b1;
    end
  end

  assign out_load_c    = s1_valid_q & (~rsp_valid_q | bus.rsp_ready);
  assign accept_c      = bus.req_valid & bus.req_ready;
  assign bus.req_ready = ~s1_valid_q | out_load_c;

  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_tag_d       = s1_tag_q;
    s1_tags_d      = s1_tags_q;
    s1_states_d    = s1_states_q;
    s1_evict_ptr_d = s1_evict_ptr_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_way_d      = rsp_way_q;
    rsp_evict_d    = rsp_evict_q;
    rsp_cls_d      = rsp_cls_q;
    rsp_forced_d   = rsp_forced_q;
    rsp_multi_d    = rsp_multi_q;
    rr_ptr_d       = rr_ptr_q;
    if (bus.flush) begin
      // Flush drops both stages, including a request offered this cycle; rr_ptr survives.
      s1_valid_d  = 1'b0;
      rsp_valid_d = 1'b0;
    end else begin
      if (out_load_c) begin
        rsp_valid_d  = 1'b1;
        rsp_way_d    = way_nx;
        rsp_evict_d  = evict_nx;
        rsp_cls_d    = cls_nx;
        rsp_forced_d = forced_nx;
        rsp_multi_d  = multi_nx;
        if (evict_nx) rr_ptr_d = way_nx + WAY_W'(1);
      end else if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
      end
      if (accept_c) begin
        s1_valid_d     = 1'b1;
        s1_tag_d       = bus.req_tag;
        s1_tags_d      = bus.req_tags;
        s1_states_d    = bus.req_states;
        s1_evict_ptr_d = bus.req_evict_ptr;
      end else if (out_load_c) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q     <= 1'b0;
      s1_tag_q       <= '0;
      s1_tags_q      <= '0;
      s1_states_q    <= '0;
      s1_evict_ptr_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_way_q      <= '0;
      rsp_evict_q    <= 1'b0;
      rsp_cls_q      <= '0;
      rsp_forced_q   <= 1'b0;
      rsp_multi_q    <= 1'b0;
      rr_ptr_q       <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_tag_q       <= s1_tag_d;
      s1_tags_q      <= s1_tags_d;
      s1_states_q    <= s1_states_d;
      s1_evict_ptr_q <= s1_evict_ptr_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_way_q      <= rsp_way_d;
      rsp_evict_q    <= rsp_evict_d;
      rsp_cls_q      <= rsp_cls_d;
      rsp_forced_q   <= rsp_forced_d;
      rsp_multi_q    <= rsp_multi_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_way       = rsp_way_q;
  assign bus.rsp_evict     = rsp_evict_q;
  assign bus.rsp_cls       = rsp_cls_q;
  assign bus.rsp_forced    = rsp_forced_q;
  assign bus.rsp_multi_hit = rsp_multi_q;

endmodule
